spram_arbiter: RTL and testbench
================================

Name: spram_arbiter

Overview:
- Round-robin arbiter that shares one 32x8 single-port RAM between N requesters.
- Owns the RAM control port (en/we/addr/wdata) and returns registered read data to the winning requester.
- Supports locked bursts so one requester can perform up to MAX_BURST consecutive accesses without interruption.
- Sits between client engines and the single-port RAM instance; the RAM has 1-cycle read latency and drives its output to 0 on any cycle it is not performing a read.

Parameters:
- N, 4, number of requesters (2..8).
- AW, 5, RAM address width.
- DW, 8, RAM data width.
- MAX_BURST, 4, maximum consecutive grants under lock (1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  per-requester access request; held until granted.
- lock  input  N  per-requester burst lock; sampled with req.
- we  input  N  per-requester write enable.
- addr  input  N*AW  flattened addresses; requester i uses bits [i*AW +: AW].
- wdata  input  N*DW  flattened write data.
- gnt  output  N  one-hot; access accepted this cycle.
- rvalid  output  N  one-hot; read data valid for requester i.
- rdata  output  DW  read data (shared bus), qualified by rvalid.
- ram_en  output  1  RAM enable.
- ram_we  output  1  RAM write enable.
- ram_addr  output  AW  RAM address.
- ram_wdata  output  DW  RAM write data.
- ram_rdata  input  DW  RAM read data (registered inside the RAM).

Behaviour:
- Reset is asynchronous and active-high.
  - Outputs: gnt=0, rvalid=0.
  - Internal state: rr_ptr=0, state=IDLE, burst_cnt=0, rd_owner=0, rd_pend=0.
  - Combinational RAM outputs evaluate to en=0, we=0, addr=0, wdata=0 while rst is high.
- Grant is combinational in the same cycle as the request.
  - gnt[i]=1 implies ram_en=1, and ram_we/addr/wdata are taken from requester i.
  - At most one gnt bit is high per cycle.
  - No req means ram_en=0 and ram_we=0.
- Round-robin selection: search starts at rr_ptr and picks the first i with req[i]=1, wrapping from N-1 to 0.
  - On each grant in IDLE, rr_ptr becomes (winner+1) mod N.
- FSM with states IDLE and BURST.
  - IDLE -> BURST when the winner has lock=1 and MAX_BURST>1. burst_cnt is set to 1 and owner is recorded.
  - In BURST only the owner can be granted; other requests wait.
  - Each owner grant increments burst_cnt.
  - BURST -> IDLE when any of the following holds:
    - owner lock=0 on a granted beat;
    - burst_cnt reaches MAX_BURST on a grant;
    - owner req=0 (no grant that cycle; the cycle is idle).
  - rr_ptr is updated to owner+1 on the BURST exit.
- Read return is fixed at 1-cycle latency.
  - A read granted at cycle T gives rvalid[owner]=1 and rdata=ram_rdata at cycle T+1.
  - rdata=0 when rvalid=0.
  - Writes produce no rvalid.
- Throughput is 1 access per cycle; back-to-back reads from different requesters are allowed.
- Addresses are used as given and wrap modulo 2^AW; there is no range checking.
- Reset asserted mid-burst or with a read in flight: the pending rvalid is dropped and the FSM returns to IDLE.
- Requester contract: req, we, addr and wdata stay stable while req=1 and gnt=0.

Optional Feature:
- Macro: SPRAM_ARB_FIXED_PRIO_EN.
- Defined:
  - Selection is fixed priority, lowest index wins.
  - rr_ptr logic is removed.
  - Burst lock still applies.
- Undefined: round-robin selection as described in Behaviour.

Decomposition:
- Package spram_arb_pkg holds:
  - the state enum (IDLE, BURST);
  - default AW/DW constants;
  - function rr_pick(req, ptr) that returns a one-hot winner.
- Sub-module rr_picker: combinational rotate/priority-encode/unrotate.
  - Reused under the macro with ptr tied to 0.

Test Plan:
- Reset then single requester: req[0]=1, we=1, addr=5, wdata=8'hA5 -> gnt[0]=1 same cycle, ram_we=1, ram_addr=5.
  - Follow-up read of addr 5 -> rvalid[0]=1 and rdata=8'hA5 the next cycle.
- All 4 requesters reading continuously, no lock -> grant order 0,1,2,3,0; gnt is one-hot every cycle; each rvalid arrives one cycle after its gnt.
- Requester 2 holds lock with MAX_BURST=4 while 0 and 3 also request -> gnt[2] for 4 consecutive cycles, then gnt[3], then gnt[0].
- Requester 1 deasserts lock on its 2nd beat -> burst ends after 2 grants; the next grant goes to the requester after index 1.
- rst pulsed on the cycle after a read grant -> rvalid stays 0, gnt=0, ram_en=0 during reset, and arbitration restarts from requester 0.
- With SPRAM_ARB_FIXED_PRIO_EN defined, req=4'b1010 held -> gnt=4'b0010 every cycle (requester 3 starves).

Source files
------------

// File: rtl/spram_arb_pkg.sv
// Shared types, default widths and the circular-priority helper for spram_arbiter.
package spram_arb_pkg;

   localparam int unsigned DefAw = 5;
   localparam int unsigned DefDw = 8;
   localparam int unsigned MaxN  = 8;

   typedef enum logic [0:0] {
      StIdle,
      StBurst
   } arb_state_e;

   // Searches the low n bits of req starting at ptr, wrapping to 0; one-hot result or all-zero.
   function automatic logic [MaxN-1:0] rr_pick(input logic [MaxN-1:0] req,
                                                input logic [2:0]      ptr,
                                                input int unsigned     n);
      logic [MaxN-1:0] gnt;
      logic            found;
      logic [3:0]      idx;
      gnt   = '0;
      found = 1'b0;
      for (int unsigned k = 0; k < MaxN; k++) begin
         if (k < n) begin
            idx = {1'b0, ptr} + 4'(k);
            if (idx >= 4'(n)) idx = idx - 4'(n);
            if (!found && req[idx[2:0]]) begin
               gnt[idx[2:0]] = 1'b1;
               found         = 1'b1;
            end
         end
      end
      return gnt;
   endfunction

endpackage

// File: rtl/spram_arbiter_if.sv
// Requester-side and RAM-side signals of spram_arbiter; slave is the arbiter's view.
interface spram_arbiter_if #(
   parameter int unsigned N  = 4,
   parameter int unsigned AW = 5,
   parameter int unsigned DW = 8
);
   logic [N-1:0]    req;
   logic [N-1:0]    lock;
   logic [N-1:0]    we;
   logic [N*AW-1:0] addr;
   logic [N*DW-1:0] wdata;
   logic [N-1:0]    gnt;
   logic [N-1:0]    rvalid;
   logic [DW-1:0]   rdata;
   logic            ram_en;
   logic            ram_we;
   logic [AW-1:0]   ram_addr;
   logic [DW-1:0]   ram_wdata;
   logic [DW-1:0]   ram_rdata;

   modport slave (
      input  req, lock, we, addr, wdata, ram_rdata,
      output gnt, rvalid, rdata, ram_en, ram_we, ram_addr, ram_wdata
   );

   modport master (
      output req, lock, we, addr, wdata, ram_rdata,
      input  gnt, rvalid, rdata, ram_en, ram_we, ram_addr, ram_wdata
   );
endinterface

// File: rtl/spram_arbiter_rr_picker.sv
// Combinational circular picker: rotate by ptr, priority-encode, unrotate; ptr=0 gives fixed priority.
module rr_picker
   import spram_arb_pkg::*;
#(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);

   logic [MaxN-1:0] req_w;
   logic [MaxN-1:0] gnt_w;
   logic [2:0]      ptr_w;

   always_comb begin
      req_w         = '0;
      req_w[N-1:0]  = req;
      ptr_w         = '0;
      ptr_w[IW-1:0] = ptr;
      gnt_w         = rr_pick(req_w, ptr_w, N);
      gnt           = gnt_w[N-1:0];
      any           = |gnt_w;
      idx           = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (gnt[i]) idx = IW'(i);
      end
   end

endmodule

// File: rtl/spram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between N requesters, with locked bursts.
// Define SPRAM_ARB_FIXED_PRIO_EN to select fixed lowest-index-first priority instead.
module spram_arbiter
   import spram_arb_pkg::*;
#(
   parameter int unsigned N         = 4,
   parameter int unsigned AW        = DefAw,
   parameter int unsigned DW        = DefDw,
   parameter int unsigned MAX_BURST = 4
) (
   input logic            clk,
   input logic            rst,
   spram_arbiter_if.slave bus
);

   localparam int unsigned IW       = $clog2(N);
   localparam logic [3:0]  BurstMax = 4'(MAX_BURST);

   arb_state_e    state_q, state_d;
   logic [3:0]    burst_cnt_q, burst_cnt_d;
   logic [IW-1:0] owner_q, owner_d;
   logic [IW-1:0] rd_owner_q;
   logic          rd_pend_q;

   logic [IW-1:0] pick_ptr, pick_idx, win, ptr_nxt;
   logic [N-1:0]  pick_gnt, gnt_oh;
   logic          pick_any, ptr_upd, en, wr;
   int unsigned   wi;

   function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
      return (32'(i) == N - 1) ? '0 : i + 1'b1;
   endfunction

   rr_picker #(
      .N  (N),
      .IW (IW)
   ) u_picker (
      .req (bus.req),
      .ptr (pick_ptr),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

`ifdef SPRAM_ARB_FIXED_PRIO_EN
   assign pick_ptr = '0;

   logic unused_ptr;
   assign unused_ptr = ^{ptr_upd, ptr_nxt};
`else
   logic [IW-1:0] rr_ptr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q <= '0;
      end else if (ptr_upd) begin
         rr_ptr_q <= ptr_nxt;
      end
   end

   assign pick_ptr = rr_ptr_q;
`endif

   always_comb begin
      state_d     = state_q;
      burst_cnt_d = burst_cnt_q;
      owner_d     = owner_q;
      gnt_oh      = '0;
      win         = '0;
      ptr_upd     = 1'b0;
      ptr_nxt     = '0;
      unique case (state_q)
         StIdle: begin
            if (pick_any) begin
               gnt_oh  = pick_gnt;
               win     = pick_idx;
               ptr_upd = 1'b1;
               ptr_nxt = wrap_inc(pick_idx);
               if (bus.lock[pick_idx] && (MAX_BURST > 1)) begin
                  state_d     = StBurst;
                  burst_cnt_d = 4'd1;
                  owner_d     = pick_idx;
               end
            end
         end
         StBurst: begin
            if (bus.req[owner_q]) begin
               gnt_oh[owner_q] = 1'b1;
               win             = owner_q;
               burst_cnt_d     = burst_cnt_q + 4'd1;
            end
            // A dropped request ends the burst on an idle cycle.
            if (!bus.req[owner_q] || !bus.lock[owner_q] || burst_cnt_d == BurstMax) begin
               state_d     = StIdle;
               burst_cnt_d = '0;
               ptr_upd     = 1'b1;
               ptr_nxt     = wrap_inc(owner_q);
            end
         end
         default: state_d = StIdle;
      endcase
      if (rst) gnt_oh = '0;
   end

   assign wi            = 32'(win);
   assign en            = |gnt_oh;
   assign wr            = en & bus.we[win];
   assign bus.gnt       = gnt_oh;
   assign bus.ram_en    = en;
   assign bus.ram_we    = wr;
   assign bus.ram_addr  = en ? bus.addr[wi*AW +: AW] : '0;
   assign bus.ram_wdata = en ? bus.wdata[wi*DW +: DW] : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         burst_cnt_q <= '0;
         owner_q     <= '0;
         rd_owner_q  <= '0;
         rd_pend_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         burst_cnt_q <= burst_cnt_d;
         owner_q     <= owner_d;
         rd_owner_q  <= win;
         rd_pend_q   <= en & ~wr;
      end
   end

   // RAM read data is already registered, so return is a pure qualify-and-steer.
   always_comb begin
      bus.rvalid = '0;
      if (rd_pend_q) bus.rvalid[rd_owner_q] = 1'b1;
   end

   assign bus.rdata = rd_pend_q ? bus.ram_rdata : '0;

endmodule

// File: tb/tb_spram_arbiter.sv
// Self-checking bench for spram_arbiter with a behavioural 32x8 RAM and a read-return scoreboard.
module tb_spram_arbiter;

   localparam int unsigned N  = 4;
   localparam int unsigned AW = 5;
   localparam int unsigned DW = 8;

   typedef struct {
      int            owner;
      logic [DW-1:0] data;
      int            due;
   } rd_exp_t;

   logic clk;
   logic rst;

   spram_arbiter_if #(.N(N), .AW(AW), .DW(DW)) bus ();

   spram_arbiter #(
      .N         (N),
      .AW        (AW),
      .DW        (DW),
      .MAX_BURST (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic          r_req   [N];
   logic          r_lock  [N];
   logic          r_we    [N];
   logic [AW-1:0] r_addr  [N];
   logic [DW-1:0] r_wdata [N];

   logic [DW-1:0] mem   [32];
   logic [DW-1:0] model [32];
   rd_exp_t       rd_q  [$];

   logic [N-1:0]  mon_v;
   logic [DW-1:0] mon_d;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Single-port RAM: 1-cycle read latency, output 0 when not reading.
   always @(posedge clk) begin
      if (bus.ram_en && bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      bus.ram_rdata <= (bus.ram_en && !bus.ram_we) ? mem[bus.ram_addr] : '0;
   end

   always @(negedge clk) begin
      mon_v = '0;
      mon_d = '0;
      if (rd_q.size() != 0 && rd_q[0].due == cyc) begin
         mon_v[rd_q[0].owner] = 1'b1;
         mon_d                = rd_q[0].data;
         void'(rd_q.pop_front());
      end
      total++;
      if (bus.rvalid !== mon_v) begin
         bad++;
         $display("FAIL sb_rvalid cyc=%0d: got %b want %b", cyc, bus.rvalid, mon_v);
      end
      total++;
      if (bus.rdata !== mon_d) begin
         bad++;
         $display("FAIL sb_rdata cyc=%0d: got %h want %h", cyc, bus.rdata, mon_d);
      end
   end

   task automatic apply();
      for (int i = 0; i < N; i++) begin
         bus.req[i]             = r_req[i];
         bus.lock[i]            = r_lock[i];
         bus.we[i]              = r_we[i];
         bus.addr[i*AW +: AW]   = r_addr[i];
         bus.wdata[i*DW +: DW]  = r_wdata[i];
      end
   endtask

   task automatic clear_reqs();
      for (int i = 0; i < N; i++) begin
         r_req[i]  = 1'b0;
         r_lock[i] = 1'b0;
         r_we[i]   = 1'b0;
      end
      apply();
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_reqs();
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Records what the bench drove for a granted requester: model update or expected read.
   task automatic note_grant(input int i);
      rd_exp_t e;
      if (r_we[i]) begin
         model[r_addr[i]] = r_wdata[i];
      end else begin
         e.owner = i;
         e.data  = model[r_addr[i]];
         e.due   = cyc + 1;
         rd_q.push_back(e);
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < N; i++) begin
         r_req[i]   = 1'b1;
         r_we[i]    = 1'b1;
         r_lock[i]  = 1'b0;
         r_addr[i]  = AW'(i + 1);
         r_wdata[i] = DW'(8'hF0 + i);
      end
      apply();
      @(negedge clk);
      total++;
      if (bus.gnt !== 4'b0000) begin
         bad++; $display("FAIL rst_gnt: got %b want 0000", bus.gnt);
      end
      total++;
      if (bus.ram_en !== 1'b0) begin
         bad++; $display("FAIL rst_ram_en: got %b want 0", bus.ram_en);
      end
      total++;
      if (bus.ram_we !== 1'b0) begin
         bad++; $display("FAIL rst_ram_we: got %b want 0", bus.ram_we);
      end
      total++;
      if (bus.ram_addr !== 5'd0) begin
         bad++; $display("FAIL rst_ram_addr: got %h want 0", bus.ram_addr);
      end
      total++;
      if (bus.ram_wdata !== 8'h00) begin
         bad++; $display("FAIL rst_ram_wdata: got %h want 00", bus.ram_wdata);
      end
      clear_reqs();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_write_read();
      r_req[0] = 1'b1; r_we[0] = 1'b1; r_addr[0] = 5'd5; r_wdata[0] = 8'hA5;
      apply();
      @(negedge clk);
      total++;
      if (bus.gnt !== 4'b0001) begin
         bad++; $display("FAIL wr_gnt: got %b want 0001", bus.gnt);
      end
      total++;
      if (bus.ram_en !== 1'b1 || bus.ram_we !== 1'b1) begin
         bad++; $display("FAIL wr_en_we: got %b%b want 11", bus.ram_en, bus.ram_we);
      end
      total++;
      if (bus.ram_addr !== 5'd5 || bus.ram_wdata !== 8'hA5) begin
         bad++; $display("FAIL wr_addr_data: got %h/%h want 05/a5", bus.ram_addr, bus.ram_wdata);
      end
      note_grant(0);
      tick();
      r_we[0] = 1'b0;
      apply();
      @(negedge clk);
      total++;
      if (bus.gnt !== 4'b0001 || bus.ram_we !== 1'b0) begin
         bad++; $display("FAIL rd_gnt: got %b we=%b want 0001 we=0", bus.gnt, bus.ram_we);
      end
      note_grant(0);
      tick();
      clear_reqs();
      @(negedge clk);
      total++;
      if (bus.rvalid !== 4'b0001 || bus.rdata !== 8'hA5) begin
         bad++; $display("FAIL rd_return: got %b/%h want 0001/a5", bus.rvalid, bus.rdata);
      end
      tick();
   endtask

   task automatic test_round_robin();
      logic [N-1:0] e;
      do_reset();
      for (int i = 0; i < N; i++) begin
         r_req[i]   = 1'b1;
         r_we[i]    = 1'b1;
         r_addr[i]  = AW'(8 + 5 * i);
         r_wdata[i] = DW'(8'h30 + 17 * i);
      end
      apply();
      for (int k = 0; k < N; k++) begin
         @(negedge clk);
         e = '0; e[k] = 1'b1;
         total++;
         if (bus.gnt !== e) begin
            bad++; $display("FAIL rr_wr_gnt k=%0d: got %b want %b", k, bus.gnt, e);
         end
         note_grant(k);
         tick();
         r_req[k] = 1'b0;
         apply();
      end
      for (int i = 0; i < N; i++) begin
         r_req[i] = 1'b1;
         r_we[i]  = 1'b0;
      end
      apply();
      for (int k = 0; k < 2 * N; k++) begin
         @(negedge clk);
         e = '0; e[k % N] = 1'b1;
         total++;
         if (bus.gnt !== e) begin
            bad++; $display("FAIL rr_rd_gnt k=%0d: got %b want %b", k, bus.gnt, e);
         end
         total++;
         if (bus.ram_addr !== AW'(8 + 5 * (k % N))) begin
            bad++; $display("FAIL rr_rd_addr k=%0d: got %h want %h", k, bus.ram_addr,
                            AW'(8 + 5 * (k % N)));
         end
         note_grant(k % N);
         tick();
      end
      clear_reqs();
      @(negedge clk);
      tick();
   endtask

   task automatic test_burst();
      int           seq [6] = '{2, 2, 2, 2, 3, 0};
      logic [N-1:0] e;
      do_reset();
      for (int i = 0; i < N; i++) begin
         r_we[i]   = 1'b0;
         r_addr[i] = AW'(8 + 5 * i);
      end
      r_req[2] = 1'b1; r_lock[2] = 1'b1;
      apply();
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         e = '0; e[seq[k]] = 1'b1;
         total++;
         if (bus.gnt !== e) begin
            bad++; $display("FAIL burst_gnt k=%0d: got %b want %b", k, bus.gnt, e);
         end
         note_grant(seq[k]);
         tick();
         if (k == 0) begin
            r_req[0] = 1'b1;
            r_req[3] = 1'b1;
         end
         if (k == 3) r_req[2] = 1'b0;
         if (k >= 4) r_req[seq[k]] = 1'b0;
         apply();
      end
      clear_reqs();
      @(negedge clk);
      tick();
   endtask

   task automatic test_lock_release();
      int           seq [4] = '{1, 1, 2, 0};
      logic [N-1:0] e;
      do_reset();
      for (int i = 0; i < N; i++) begin
         r_we[i]   = 1'b0;
         r_addr[i] = AW'(8 + 5 * i);
      end
      r_req[1] = 1'b1; r_lock[1] = 1'b1;
      apply();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         e = '0; e[seq[k]] = 1'b1;
         total++;
         if (bus.gnt !== e) begin
            bad++; $display("FAIL unlock_gnt k=%0d: got %b want %b", k, bus.gnt, e);
         end
         note_grant(seq[k]);
         tick();
         if (k == 0) begin
            r_lock[1] = 1'b0;
            r_req[0]  = 1'b1;
            r_req[2]  = 1'b1;
         end else begin
            r_req[seq[k]] = 1'b0;
         end
         apply();
      end
      clear_reqs();
      @(negedge clk);
      tick();
   endtask

   task automatic test_fixed_prio();
      do_reset();
      for (int i = 0; i < N; i++) begin
         r_we[i]   = 1'b0;
         r_addr[i] = 5'd5;
      end
      r_req[1] = 1'b1; r_req[3] = 1'b1;
      apply();
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         total++;
         if (bus.gnt !== 4'b0010) begin
            bad++; $display("FAIL fixed_gnt k=%0d: got %b want 0010", k, bus.gnt);
         end
         note_grant(1);
         tick();
      end
      clear_reqs();
      @(negedge clk);
      tick();
   endtask

   task automatic test_reset_inflight();
      do_reset();
      for (int i = 0; i < N; i++) begin
         r_we[i]   = 1'b0;
         r_addr[i] = 5'd5;
      end
      r_req[2] = 1'b1;
      apply();
      @(negedge clk);
      total++;
      if (bus.gnt !== 4'b0100) begin
         bad++; $display("FAIL inflight_gnt: got %b want 0100", bus.gnt);
      end
      tick();
      rst = 1'b1;
      for (int i = 0; i < N; i++) r_req[i] = 1'b1;
      apply();
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         total++;
         if (bus.gnt !== 4'b0000 || bus.ram_en !== 1'b0) begin
            bad++; $display("FAIL inflight_rst k=%0d: got gnt=%b en=%b want 0000/0", k, bus.gnt,
                            bus.ram_en);
         end
         total++;
         if (bus.rvalid !== 4'b0000) begin
            bad++; $display("FAIL inflight_rvalid k=%0d: got %b want 0000", k, bus.rvalid);
         end
         tick();
      end
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (bus.gnt !== 4'b0001) begin
         bad++; $display("FAIL restart_gnt: got %b want 0001", bus.gnt);
      end
      note_grant(0);
      tick();
      clear_reqs();
      @(negedge clk);
      tick();
   endtask

   initial begin
      rst = 1'b0;
      for (int i = 0; i < N; i++) begin
         r_addr[i]  = '0;
         r_wdata[i] = '0;
      end
      clear_reqs();
      bus.ram_rdata = '0;
      #2 rst = 1'b1;
      test_reset();
      test_write_read();
`ifdef SPRAM_ARB_FIXED_PRIO_EN
      test_fixed_prio();
`else
      test_round_robin();
      test_burst();
      test_lock_release();
`endif
      test_reset_inflight();
      tick();
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
